// File: rtl/hb_fir_tdm.sv
// Time-multiplexed symmetric / halfband FIR.
// One shared multiplier walks the folded taps.
module hb_fir_tdm #(
  parameter int WIDTH    = 18,
  parameter int CWIDTH   = 18,
  parameter int NTAPS    = 15,
  parameter int HALFBAND = 1,
  localparam int M       = (NTAPS - 1) / 2,
  localparam int CAW     = $clog2(M + 1)
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  x_in,
  input  logic                     coeff_wr,
  input  logic [CAW-1:0]           coeff_addr,
  input  logic signed [CWIDTH-1:0] coeff_data,
  output logic signed [WIDTH-1:0]  y,
  output logic                     out_valid
);

  localparam int NMAC = (HALFBAND != 0) ? (M + 1) / 2 : M + 1;
  localparam int CNTW = $clog2(NMAC + 1);
  localparam int FW   = WIDTH + 1;
  localparam int PW   = FW + CWIDTH;
  localparam int AW   = WIDTH + CWIDTH + 1 + CAW;

  localparam logic signed [AW-1:0] HALF =
    AW'(1) <<< (CWIDTH - 2);
  localparam logic signed [AW-1:0] YMAX =
    {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN =
    {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic signed [WIDTH-1:0]  dl [NTAPS];
  logic signed [CWIDTH-1:0] coef [0:M];
  logic [CNTW-1:0]          cnt;
  logic                     pv;
  logic signed [PW-1:0]     prod_q;
  logic signed [AW-1:0]     acc;

  logic                     accept;
  logic                     last;
  logic                     start;
  logic                     cw_ok;
  int                       k;
  logic signed [WIDTH-1:0]  lo, hi;
  logic signed [CWIDTH-1:0] c;
  logic signed [FW-1:0]     fold;
  logic signed [AW-1:0]     centre;
  logic signed [AW-1:0]     base;
  logic signed [AW-1:0]     acc_sum;
  logic signed [AW-1:0]     rnd;
  logic signed [AW-1:0]     shr;
  logic signed [WIDTH-1:0]  y_sat;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNTW'(NMAC - 1));
  assign start    = (state == MAC) && (cnt == '0);
  assign cw_ok    = coeff_wr && in_ready &&
                    (32'(coeff_addr) <= M);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (last) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Halfband walks k = M-1, M-3, ... ; general walks 0..M.
  always_comb begin
    if (HALFBAND != 0) k = M - 1 - 2 * int'(cnt);
    else k = int'(cnt);
    lo = '0;
    hi = '0;
    c  = '0;
    for (int i = 0; i <= M; i++) begin
      if (k == i) begin
        lo = dl[i];
        hi = dl[NTAPS-1-i];
        c  = coef[i];
      end
    end
    if (k == M) fold = {lo[WIDTH-1], lo};
    else fold = {lo[WIDTH-1], lo} + {hi[WIDTH-1], hi};
  end

  // h[M] = 0.5 in halfband mode is a plain shift.
  always_comb begin
    centre = AW'(dl[M]) <<< (CWIDTH - 2);
    base   = (HALFBAND != 0) ? centre : '0;
    acc_sum = (start ? base : acc) +
              (pv ? AW'(prod_q) : '0);
    rnd = acc_sum + HALF;
    shr = rnd >>> (CWIDTH - 1);
    if (shr > YMAX) y_sat = YMAX[WIDTH-1:0];
    else if (shr < YMIN) y_sat = YMIN[WIDTH-1:0];
    else y_sat = shr[WIDTH-1:0];
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pv        <= 1'b0;
      prod_q    <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) dl[i] <= '0;
      for (int i = 0; i <= M; i++) coef[i] <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= (state == DRAIN);
      pv        <= (state == MAC);
      if (accept) begin
        dl[0] <= x_in;
        for (int i = 1; i < NTAPS; i++) dl[i] <= dl[i-1];
      end
      if (cw_ok) coef[coeff_addr] <= coeff_data;
      if (state == MAC) begin
        prod_q <= PW'(fold) * PW'(c);
        cnt    <= last ? '0 : cnt + CNTW'(1);
      end
      if (state != IDLE) acc <= acc_sum;
      if (state == DRAIN) y <= y_sat;
    end
  end

endmodule

// File: tb/tb_hb_fir_tdm.sv
// Scoreboard bench: halfband N=15 unit and general N=5 unit.
// Expected outputs are hand-computed and queued at accept time.
module tb_hb_fir_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n [2];
  logic              iv [2];
  logic              ir [2];
  logic              cw [2];
  logic              ov [2];
  logic signed [17:0] xi [2];
  logic signed [17:0] cd [2];
  logic signed [17:0] yo [2];
  logic [2:0]        ca0;
  logic [1:0]        ca1;

  hb_fir_tdm #(
    .WIDTH(18), .CWIDTH(18), .NTAPS(15), .HALFBAND(1)
  ) u_hb (
    .sys_clk(clk), .reset_n(rst_n[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .x_in(xi[0]),
    .coeff_wr(cw[0]), .coeff_addr(ca0),
    .coeff_data(cd[0]), .y(yo[0]), .out_valid(ov[0])
  );

  hb_fir_tdm #(
    .WIDTH(18), .CWIDTH(18), .NTAPS(5), .HALFBAND(0)
  ) u_gen (
    .sys_clk(clk), .reset_n(rst_n[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .x_in(xi[1]),
    .coeff_wr(cw[1]), .coeff_addr(ca1),
    .coeff_data(cd[1]), .y(yo[1]), .out_valid(ov[1])
  );

  typedef struct {
    int                u;
    logic signed [17:0] y;
    int                c;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  // accept-to-out_valid latency: NMAC+2 (hb: 4+2, gen: 3+2)
  int lat [2] = '{6, 5};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (ov[u]) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'(ov[u]), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_unit", u, e.u);
          check("y_value", yo[u], e.y);
          check("latency", cyc - e.c, lat[u]);
        end
      end
    end
  end

  task automatic send(input int u,
                      input logic signed [17:0] x,
                      input logic signed [17:0] e,
                      input bit push,
                      input bit hold,
                      output int w);
    exp_t t;
    w = 0;
    iv[u] = 1'b1;
    xi[u] = x;
    while (!ir[u] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ir[u]) check("accept_timeout", 32'(ir[u]), 1);
    else if (push) begin
      t.u = u;
      t.y = e;
      t.c = cyc;
      q.push_back(t);
    end
    @(negedge clk);
    if (!hold) iv[u] = 1'b0;
  endtask

  task automatic wr(input int u, input int a,
                    input logic signed [17:0] d);
    cw[u] = 1'b1;
    if (u == 0) ca0 = 3'(a);
    else ca1 = 2'(a);
    cd[u] = d;
    @(negedge clk);
    cw[u] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  int imp [15] = '{-87, 0, 819, 0, -3981, 0, 19634,
                   32768, 19634, 0, -3981, 0, 819, 0, -87};
  int gimp [6] = '{512, 1024, 2048, 1024, 512, 0};

  initial begin
    int w;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0;
      iv[u] = 1'b0;
      cw[u] = 1'b0;
      xi[u] = '0;
      cd[u] = '0;
    end
    ca0 = '0;
    ca1 = '0;
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", 32'(ir[u]), 1);
      check("rst_out_valid", 32'(ov[u]), 0);
      check("rst_y", yo[u], 0);
    end

    // halfband: load taps, plus unused centre/skipped taps
    wr(0, 0, -174);
    wr(0, 2, 1637);
    wr(0, 4, -7962);
    wr(0, 6, 39267);
    wr(0, 7, 5000);
    wr(0, 1, 7777);
    for (int i = 0; i < 15; i++) begin
      send(0, (i == 0) ? 18'sd65536 : 18'sd0,
           18'(imp[i]), 1'b1, 1'b1, w);
      if (i > 0) check("hb_gap", w, lat[0] - 1);
    end
    iv[0] = 1'b0;
    drain();

    // write during MAC must be dropped
    send(0, 18'sd65536, 18'(imp[0]), 1'b1, 1'b0, w);
    wr(0, 0, 999);
    for (int i = 1; i < 15; i++) begin
      send(0, 18'sd0, 18'(imp[i]), 1'b1, 1'b0, w);
      if (i == 3) wr(0, 2, -999);
    end
    drain();

    // reset mid-MAC discards the sample and the coefficients
    send(0, 18'sd65536, 18'sd0, 1'b0, 1'b0, w);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(ir[0]), 1);
    check("mid_rst_out_valid", 32'(ov[0]), 0);
    check("mid_rst_y", yo[0], 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(ir[0]), 1);
    check("post_rst_y", yo[0], 0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++)
      send(0, (i == 0) ? 18'sd65536 : 18'sd0,
           18'sd0, 1'b1, 1'b0, w);
    drain();

    // general N=5: distinct taps, dropped address 3,
    // and h0 written in the same cycle as the accept
    wr(1, 1, 32768);
    wr(1, 2, 65536);
    wr(1, 3, 131071);
    cw[1] = 1'b1;
    ca1 = 2'd0;
    cd[1] = 18'sd16384;
    for (int i = 0; i < 6; i++) begin
      send(1, (i == 0) ? 18'sd4096 : 18'sd0,
           18'(gimp[i]), 1'b1, 1'b1, w);
      cw[1] = 1'b0;
      if (i > 0) check("gen_gap", w, lat[1] - 1);
    end
    iv[1] = 1'b0;
    drain();

    // saturation with full-scale taps
    for (int a = 0; a < 3; a++) wr(1, a, 131071);
    for (int i = 0; i < 15; i++)
      send(1, 18'sd131071,
           (i == 0) ? 18'sd131070 : 18'sd131071,
           1'b1, 1'b1, w);
    for (int i = 0; i < 15; i++)
      send(1, -18'sd131072,
           (i == 0) ? 18'sd131071 :
           (i == 1) ? 18'sd131068 : -18'sd131072,
           1'b1, 1'b1, w);
    iv[1] = 1'b0;
    drain();

    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
